cmem_arbiter: RTL and testbench

CMEM_ARBITER -- requirements
Module: cmem_arbiter

---
 rtl/cmem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_cmem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmem_arbiter.sv
//----------------------------------------------------------------------------
// cmem_arbiter
//
// Two-requester arbiter in front of a single-ported layer memory. Requester 0
// is the layer-0 engine and requester 1 is the layer-1 engine. Each cycle at
// most one request is granted. The granted command is registered onto the
// memory command outputs one cycle later. Read data returned by the memory
// two cycles after acceptance is routed back to the requester that issued it.
//
// Arbitration:
//   - Default build: round-robin. The requester not granted most recently
//     wins a tie. After reset, requester 0 wins the first tie.
//   - `define CMEM_ARB_FIXED_PRIO_EN: fixed priority, requester 1 wins ties.
//   - Either way, an accepted command with its lock input high enters HOLD.
//     In HOLD the grant stays with that requester for up to MAX_BURST
//     consecutive accepts.
//
// Parameters:
//   MAX_BURST  maximum consecutive grants to one locked requester (1..255)
//
// Ports:
//   clk                    rising-edge clock
//   reset                  synchronous reset, active-low
//   req0/req1              access request
//   lock0/lock1            burst hold while req stays high
//   we0/we1                1 = write, 0 = read
//   addr0/addr1   [11:0]   memory address
//   wdata0/wdata1 [19:0]   write data
//   sel0/sel1     [2:0]    target memory select
//   gnt0/gnt1              combinational grant (accept = req & gnt)
//   rvalid0/rvalid1        one-cycle read-return strobe
//   rdata0/rdata1 [19:0]   read data (holds last value when not returning)
//   cwr, caddr_wr, cdata_wr  write command to the memory
//   crd, caddr_rd            read command to the memory
//   cdata_rd      [19:0]   read data from the memory (two cycles after accept)
//   csel          [2:0]    memory select of the current command
//   idle                   no command on the outputs, no read return in flight
//----------------------------------------------------------------------------
module cmem_arbiter #(
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic        we0,
    input  logic        we1,
    input  logic [11:0] addr0,
    input  logic [11:0] addr1,
    input  logic [19:0] wdata0,
    input  logic [19:0] wdata1,
    input  logic [2:0]  sel0,
    input  logic [2:0]  sel1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [19:0] rdata0,
    output logic [19:0] rdata1,
    output logic        cwr,
    output logic [11:0] caddr_wr,
    output logic [19:0] cdata_wr,
    output logic        crd,
    output logic [11:0] caddr_rd,
    input  logic [19:0] cdata_rd,
    output logic [2:0]  csel,
    output logic        idle
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    // Per-requester views of the inputs, indexed by requester id.
    logic [1:0]  req_v;
    logic [1:0]  lock_v;
    logic [1:0]  we_v;
    logic [11:0] addr_v  [2];
    logic [19:0] wdata_v [2];
    logic [2:0]  sel_v   [2];

    assign req_v      = {req1, req0};
    assign lock_v     = {lock1, lock0};
    assign we_v       = {we1, we0};
    assign addr_v[0]  = addr0;
    assign addr_v[1]  = addr1;
    assign wdata_v[0] = wdata0;
    assign wdata_v[1] = wdata1;
    assign sel_v[0]   = sel0;
    assign sel_v[1]   = sel1;

    // FSM state
    state_t     state_reg;
    logic [7:0] burst_reg;

    // Arbitration signals
    logic       tie_base;     // tie winner when no hold override applies
    logic       tie_pick;     // tie winner this cycle
    logic       hold_id;      // requester owning the current HOLD state
    logic       hold_req;     // the holder still asks to keep the grant
    logic       hold_active;  // the hold is honoured this cycle
    logic       max_exit;     // the hold ends only because the burst is used up
    logic [1:0] gnt_v;
    logic       accept;
    logic       win_id;

    // Command / return path registers
    logic        cwr_reg;
    logic        crd_reg;
    logic [11:0] caddr_wr_reg;
    logic [11:0] caddr_rd_reg;
    logic [19:0] cdata_wr_reg;
    logic [2:0]  csel_reg;
    logic        rd_tag_reg;     // requester of the read now on crd
    logic        ret_valid_reg;  // memory is returning read data this cycle
    logic        ret_tag_reg;    // requester that data belongs to

    //------------------------------------------------------------------------
    // Tie-break source
    //------------------------------------------------------------------------
`ifdef CMEM_ARB_FIXED_PRIO_EN
    assign tie_base = 1'b1;
`else
    // prio_reg names the requester that wins the next tie. It always points
    // at the requester that was not granted most recently.
    logic prio_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_reg <= 1'b0;
        end else if (accept) begin
            prio_reg <= ~win_id;
        end
    end

    assign tie_base = prio_reg;
`endif

    //------------------------------------------------------------------------
    // Grant logic
    //
    // The HOLD exit conditions are evaluated in the same cycle they occur.
    // So a holder that drops req or lock, or has used up its burst, gives the
    // grant back immediately, and the other requester can be granted in that
    // cycle. On a burst-limit exit, the other requester is forced to win the
    // tie, even with fixed priority.
    //------------------------------------------------------------------------
    always_comb begin
        hold_id     = (state_reg == HOLD1);
        hold_req    = (state_reg != ARB) && req_v[hold_id] && lock_v[hold_id];
        hold_active = hold_req && (burst_reg < BURST_MAX);
        max_exit    = hold_req && !hold_active;
        tie_pick    = max_exit ? ~hold_id : tie_base;
        gnt_v       = 2'b00;
        // No commands are accepted while reset is asserted.
        if (reset) begin
            if (hold_active) begin
                gnt_v[hold_id] = 1'b1;
            end else if (req_v == 2'b11) begin
                gnt_v[tie_pick] = 1'b1;
            end else begin
                gnt_v = req_v;
            end
        end
    end

    assign accept = |gnt_v;
    assign win_id = gnt_v[1];
    assign gnt0   = gnt_v[0];
    assign gnt1   = gnt_v[1];

    //------------------------------------------------------------------------
    // FSM: ARB / HOLD0 / HOLD1 with burst counter
    //
    // burst_reg counts accepts since entering HOLD. It is set to 1 by the
    // accept that enters HOLD. A holder that is re-granted after a
    // burst-limit exit starts a new burst, because no one else was waiting.
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ARB;
            burst_reg <= '0;
        end else if (accept) begin
            if (hold_active) begin
                burst_reg <= burst_reg + 8'd1;
            end else if (lock_v[win_id]) begin
                state_reg <= win_id ? HOLD1 : HOLD0;
                burst_reg <= 8'd1;
            end else begin
                state_reg <= ARB;
                burst_reg <= '0;
            end
        end else begin
            state_reg <= ARB;
            burst_reg <= '0;
        end
    end

    //------------------------------------------------------------------------
    // Command register stage
    //
    // Write accepts update caddr_wr and cdata_wr. Read accepts update
    // caddr_rd. Every accept updates csel. The address, data and select
    // registers keep their values when nothing is accepted. Only the strobes
    // fall back to 0.
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            cwr_reg      <= 1'b0;
            crd_reg      <= 1'b0;
            caddr_wr_reg <= '0;
            caddr_rd_reg <= '0;
            cdata_wr_reg <= '0;
            csel_reg     <= '0;
            rd_tag_reg   <= 1'b0;
        end else begin
            cwr_reg <= accept &&  we_v[win_id];
            crd_reg <= accept && !we_v[win_id];
            if (accept) begin
                csel_reg <= sel_v[win_id];
                if (we_v[win_id]) begin
                    caddr_wr_reg <= addr_v[win_id];
                    cdata_wr_reg <= wdata_v[win_id];
                end else begin
                    caddr_rd_reg <= addr_v[win_id];
                    rd_tag_reg   <= win_id;
                end
            end
        end
    end

    assign cwr      = cwr_reg;
    assign crd      = crd_reg;
    assign caddr_wr = caddr_wr_reg;
    assign caddr_rd = caddr_rd_reg;
    assign cdata_wr = cdata_wr_reg;
    assign csel     = csel_reg;

    //------------------------------------------------------------------------
    // Read return tracking
    //
    // A read shows on crd in cycle t+1, and the memory drives cdata_rd in
    // cycle t+2. The requester tag follows the read one stage behind crd, so
    // interleaved reads from both requesters return in order. Reset clears
    // this stage, which drops any read still in flight.
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            ret_valid_reg <= 1'b0;
            ret_tag_reg   <= 1'b0;
        end else begin
            ret_valid_reg <= crd_reg;
            ret_tag_reg   <= rd_tag_reg;
        end
    end

    logic [1:0]  rvalid_v;
    logic [19:0] rdata_v [2];

    // rdata passes cdata_rd straight through in the return cycle. In every
    // other cycle it shows the value captured at that requester's last
    // return.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        logic [19:0] rdata_hold_reg;

        assign rvalid_v[gi] = ret_valid_reg && (ret_tag_reg == 1'(gi));

        always_ff @(posedge clk) begin
            if (!reset) begin
                rdata_hold_reg <= '0;
            end else if (rvalid_v[gi]) begin
                rdata_hold_reg <= cdata_rd;
            end
        end

        assign rdata_v[gi] = rvalid_v[gi] ? cdata_rd : rdata_hold_reg;
    end

    assign rvalid0 = rvalid_v[0];
    assign rvalid1 = rvalid_v[1];
    assign rdata0  = rdata_v[0];
    assign rdata1  = rdata_v[1];

    // The return cycle itself counts as in flight.
    assign idle = !(cwr_reg || crd_reg || ret_valid_reg);

endmodule

// File: tb/tb_cmem_arbiter.sv
//----------------------------------------------------------------------------
// tb_cmem_arbiter
//
// Drives cmem_arbiter (MAX_BURST = 4) from a table of per-cycle request
// vectors with the expected grants. A small command model gives the expected
// memory command outputs and idle. Read returns are checked by a scoreboard
// queue. Hand-written sequences cover reset during an outstanding read and
// lock release. A behavioural memory returns data two cycles after a read is
// accepted and drives random values in all other cycles.
//----------------------------------------------------------------------------
module tb_cmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [11:0] addr0, addr1;
    logic [19:0] wdata0, wdata1;
    logic [2:0]  sel0, sel1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [19:0] rdata0, rdata1;
    logic        cwr, crd, idle;
    logic [11:0] caddr_wr, caddr_rd;
    logic [19:0] cdata_wr, cdata_rd;
    logic [2:0]  csel;

    cmem_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .sel0(sel0), .sel1(sel1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .idle(idle)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed pattern, with 0FF holding ABCDE.
    function automatic logic [19:0] rom(input logic [11:0] a);
        if (a == 12'h0FF) return 20'hABCDE;
        return {a, 8'h5C} ^ 20'h0F0F0;
    endfunction

    // The memory registers the read address, so data appears the cycle after
    // crd. In all other cycles it drives junk.
    logic [19:0] mem_q = 20'h0;
    always @(posedge clk) mem_q <= crd ? rom(caddr_rd) : 20'($urandom);
    assign cdata_rd = mem_q;

    typedef struct {
        logic        r0, r1, l0, l1, w0, w1;
        logic [11:0] a0, a1;
        logic [19:0] d0, d1;
        logic [2:0]  s0, s1;
        logic        g0, g1;
    } vec_t;

    typedef struct {
        int          id;
        logic [19:0] data;
        int          due;
    } sb_t;

    localparam int NV = 25;
    vec_t vt [NV];
    sb_t  sb [$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        rst_edge = 1'b0;
    logic [19:0] last_rd [2];

    // Expected command outputs
    logic        e_cwr = 1'b0, e_crd = 1'b0, e_ret = 1'b0;
    logic [11:0] e_caddr_wr = '0, e_caddr_rd = '0;
    logic [19:0] e_cdata_wr = '0;
    logic [2:0]  e_csel = '0;
    logic        acc, wid, a_we;
    logic [11:0] a_addr;
    logic        tg0, tg1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle_start();
        @(posedge clk);
        rst_edge = !reset;
        cyc++;
        #1;
    endtask

    task automatic mon_one(input int id, input logic rv, input logic [19:0] rd);
        sb_t e;
        if (rv) begin
            if (sb.size() == 0) begin
                chk($sformatf("rvalid%0d_unexpected", id), 32'(rv), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("ret_id", 32'(id), 32'(e.id));
                chk("ret_data", 32'(rd), 32'(e.data));
                chk("ret_cycle", 32'(cyc), 32'(e.due));
                $display("read return req%0d data=%h cycle=%0d", id, rd, cyc);
                last_rd[id] = rd;
            end
        end else begin
            chk($sformatf("rdata%0d_hold", id), 32'(rd), 32'(last_rd[id]));
        end
    endtask

    // Sample point mid-cycle (falling edge), then run the return monitor.
    task automatic mid();
        @(negedge clk);
        if (rst_edge) begin
            last_rd[0] = '0;
            last_rd[1] = '0;
        end
        while (sb.size() != 0 && sb[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL ret_missing req%0d due=%0d now=%0d", sb[0].id, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        mon_one(0, rvalid0, rdata0);
        mon_one(1, rvalid1, rdata1);
    endtask

    task automatic drive(input vec_t v);
        req0 = v.r0; req1 = v.r1; lock0 = v.l0; lock1 = v.l1;
        we0 = v.w0; we1 = v.w1; addr0 = v.a0; addr1 = v.a1;
        wdata0 = v.d0; wdata1 = v.d1; sel0 = v.s0; sel1 = v.s1;
    endtask

    function automatic vec_t zv();
        vec_t v;
        v = '{r0: 1'b0, r1: 1'b0, l0: 1'b0, l1: 1'b0, w0: 1'b0, w1: 1'b0,
              a0: 12'h0, a1: 12'h0, d0: 20'h0, d1: 20'h0, s0: 3'd0, s1: 3'd0,
              g0: 1'b0, g1: 1'b0};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        last_rd[0] = '0;
        last_rd[1] = '0;

        //--------------------------------------------------------------
        // Vector table: one row per cycle
        //--------------------------------------------------------------
        for (int i = 0; i < NV; i++) vt[i] = zv();
        // r0: write from requester 0
        v = zv(); v.r0 = 1'b1; v.w0 = 1'b1; v.a0 = 12'h010; v.d0 = 20'h12345; v.s0 = 3'd1; v.g0 = 1'b1;
        vt[0] = v;
        // r1: write from requester 1, so requester 0 wins the next tie
        v = zv(); v.r1 = 1'b1; v.w1 = 1'b1; v.a1 = 12'h011; v.d1 = 20'h54321; v.s1 = 3'd5; v.g1 = 1'b1;
        vt[1] = v;
        // r2..r5: both requesting, no lock
        for (int k = 0; k < 4; k++) begin
            v = zv(); v.r0 = 1'b1; v.r1 = 1'b1; v.w0 = 1'b1; v.w1 = 1'b1;
            v.a0 = 12'(12'h100 + k); v.a1 = 12'(12'h200 + k);
            v.d0 = 20'(20'h0A000 + k); v.d1 = 20'(20'h0B000 + k);
            v.s0 = 3'd2; v.s1 = 3'd3;
`ifdef CMEM_ARB_FIXED_PRIO_EN
            v.g0 = 1'b0; v.g1 = 1'b1;
`else
            v.g0 = ((k % 2) == 0); v.g1 = ((k % 2) == 1);
`endif
            vt[2 + k] = v;
        end
        // r7: read from requester 1, addr 0FF
        v = zv(); v.r1 = 1'b1; v.a1 = 12'h0FF; v.s1 = 3'd2; v.g1 = 1'b1;
        vt[7] = v;
        // r11..r13: full-rate reads 0,1,0
        v = zv(); v.r0 = 1'b1; v.a0 = 12'h020; v.s0 = 3'd4; v.g0 = 1'b1; vt[11] = v;
        v = zv(); v.r1 = 1'b1; v.a1 = 12'h021; v.s1 = 3'd6; v.g1 = 1'b1; vt[12] = v;
        v = zv(); v.r0 = 1'b1; v.a0 = 12'h022; v.s0 = 3'd7; v.g0 = 1'b1; vt[13] = v;
        // r17..r22: req0, req1 and lock1 held -> 1,1,1,1,0,1
        for (int k = 0; k < 6; k++) begin
            v = zv(); v.r0 = 1'b1; v.r1 = 1'b1; v.l1 = 1'b1; v.w0 = 1'b1; v.w1 = 1'b1;
            v.a0 = 12'(12'h300 + k); v.a1 = 12'(12'h310 + k);
            v.d0 = 20'(20'h0C000 + k); v.d1 = 20'(20'h0D000 + k);
            v.s0 = 3'd1; v.s1 = 3'd6;
            v.g0 = (k == 4); v.g1 = (k != 4);
            vt[17 + k] = v;
        end
        // r23: holder drops req with lock still high -> requester 0 same cycle
        v = zv(); v.r0 = 1'b1; v.l1 = 1'b1; v.w0 = 1'b1; v.a0 = 12'h3F0; v.d0 = 20'hFEDCB; v.s0 = 3'd3; v.g0 = 1'b1;
        vt[23] = v;

        //--------------------------------------------------------------
        // Reset
        //--------------------------------------------------------------
        drive(zv());
        reset = 1'b0;
        repeat (3) cycle_start();
        reset = 1'b1;
        mid();
        chk("rst_gnt0", 32'(gnt0), 32'(0));
        chk("rst_gnt1", 32'(gnt1), 32'(0));
        chk("rst_cwr", 32'(cwr), 32'(0));
        chk("rst_crd", 32'(crd), 32'(0));
        chk("rst_caddr_wr", 32'(caddr_wr), 32'(0));
        chk("rst_caddr_rd", 32'(caddr_rd), 32'(0));
        chk("rst_cdata_wr", 32'(cdata_wr), 32'(0));
        chk("rst_csel", 32'(csel), 32'(0));
        chk("rst_rvalid0", 32'(rvalid0), 32'(0));
        chk("rst_rvalid1", 32'(rvalid1), 32'(0));
        chk("rst_idle", 32'(idle), 32'(1));

        //--------------------------------------------------------------
        // Table-driven run
        //--------------------------------------------------------------
        for (int i = 0; i < NV; i++) begin
            cycle_start();
            drive(vt[i]);
            mid();
            tg0 = gnt0;
            tg1 = gnt1;
            chk("gnt0", 32'(gnt0), 32'(vt[i].g0));
            chk("gnt1", 32'(gnt1), 32'(vt[i].g1));
            chk("cwr", 32'(cwr), 32'(e_cwr));
            chk("crd", 32'(crd), 32'(e_crd));
            chk("caddr_wr", 32'(caddr_wr), 32'(e_caddr_wr));
            chk("caddr_rd", 32'(caddr_rd), 32'(e_caddr_rd));
            chk("cdata_wr", 32'(cdata_wr), 32'(e_cdata_wr));
            chk("csel", 32'(csel), 32'(e_csel));
            chk("idle", 32'(idle), 32'(!(e_cwr || e_crd || e_ret)));
            $display("row %0d cycle=%0d gnt=%b%b cwr=%b crd=%b csel=%0d idle=%b",
                     i, cyc, tg1, tg0, cwr, crd, csel, idle);
            // Advance the expected command outputs with this row's accept.
            acc    = vt[i].g0 | vt[i].g1;
            wid    = vt[i].g1;
            a_we   = wid ? vt[i].w1 : vt[i].w0;
            a_addr = wid ? vt[i].a1 : vt[i].a0;
            e_ret  = e_crd;
            e_cwr  = acc && a_we;
            e_crd  = acc && !a_we;
            if (acc) begin
                e_csel = wid ? vt[i].s1 : vt[i].s0;
                if (a_we) begin
                    e_caddr_wr = a_addr;
                    e_cdata_wr = wid ? vt[i].d1 : vt[i].d0;
                end else begin
                    e_caddr_rd = a_addr;
                    sb.push_back('{id: int'(wid), data: rom(a_addr), due: cyc + 2});
                end
            end
        end

        //--------------------------------------------------------------
        // Reset while a read is outstanding: the return is dropped
        //--------------------------------------------------------------
        cycle_start();
        v = zv(); v.r0 = 1'b1; v.a0 = 12'h030; v.s0 = 3'd3;
        drive(v);
        mid();
        chk("rr_gnt0", 32'(gnt0), 32'(1));
        $display("reset-during-read: read accepted cycle=%0d", cyc);
        cycle_start();
        drive(zv());
        reset = 1'b0;
        mid();
        chk("rr_crd", 32'(crd), 32'(1));
        cycle_start();
        reset = 1'b1;
        mid();
        chk("rr_rvalid0", 32'(rvalid0), 32'(0));
        chk("rr_rvalid1", 32'(rvalid1), 32'(0));
        chk("rr_cwr", 32'(cwr), 32'(0));
        chk("rr_crd_clr", 32'(crd), 32'(0));
        chk("rr_caddr_rd", 32'(caddr_rd), 32'(0));
        chk("rr_caddr_wr", 32'(caddr_wr), 32'(0));
        chk("rr_cdata_wr", 32'(cdata_wr), 32'(0));
        chk("rr_csel", 32'(csel), 32'(0));
        chk("rr_idle", 32'(idle), 32'(1));
        $display("reset-during-read: checked cycle=%0d rvalid=%b%b idle=%b", cyc, rvalid1, rvalid0, idle);

        //--------------------------------------------------------------
        // Lock dropped in HOLD0 releases the grant in the same cycle
        //--------------------------------------------------------------
        cycle_start();
        v = zv(); v.r0 = 1'b1; v.l0 = 1'b1; v.w0 = 1'b1; v.a0 = 12'h040; v.d0 = 20'h11111;
        drive(v);
        mid();
        chk("lk_c0_gnt0", 32'(gnt0), 32'(1));
        cycle_start();
        v.r1 = 1'b1; v.w1 = 1'b1; v.a1 = 12'h041; v.d1 = 20'h22222;
        drive(v);
        mid();
        chk("lk_c1_gnt0", 32'(gnt0), 32'(1));
        chk("lk_c1_gnt1", 32'(gnt1), 32'(0));
        chk("lk_c1_cdata_wr", 32'(cdata_wr), 32'(20'h11111));
        cycle_start();
        v.l0 = 1'b0;
        drive(v);
        mid();
        chk("lk_c2_gnt0", 32'(gnt0), 32'(0));
        chk("lk_c2_gnt1", 32'(gnt1), 32'(1));
        cycle_start();
        v.l0 = 1'b1;
        drive(v);
        mid();
`ifdef CMEM_ARB_FIXED_PRIO_EN
        chk("lk_c3_gnt1", 32'(gnt1), 32'(1));
`else
        chk("lk_c3_gnt0", 32'(gnt0), 32'(1));
`endif
        $display("lock release sequence done cycle=%0d", cyc);

        cycle_start();
        drive(zv());
        mid();
        repeat (3) begin
            cycle_start();
            mid();
        end
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
